// File: rtl/lr_shifter_pipe.sv
// Pipelined logical-right barrel shifter with valid/ready handshakes.
// Stage k conditionally shifts right by 2^k using bit k of the shift amount,
// and the operand's tag travels with it so results can be matched downstream.
// Each stage loads whenever some stage at or after it is empty (or the sink is
// taking the final result), so bubbles collapse under backpressure.

module lr_shifter_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Per-stage registered state
  logic [SHW-1:0]             v_q;
  logic [SHW-1:0][WIDTH-1:0]  d_q;
  logic [SHW-1:0][SHW-1:0]    s_q;
  logic [SHW-1:0][TAG_W-1:0]  t_q;

  // Upstream view of each stage and the shifted data it would load
  logic [SHW-1:0]             up_v;
  logic [SHW-1:0][WIDTH-1:0]  up_d;
  logic [SHW-1:0][SHW-1:0]    up_s;
  logic [SHW-1:0][TAG_W-1:0]  up_t;
  logic [SHW-1:0][WIDTH-1:0]  d_d;

  // Per-stage load enable
  logic [SHW-1:0]             rdy;

  // Each stage only consumes one shamt bit; the rest are carried for later
  // stages, and the final stage's copy is kept purely for uniformity.
  logic                       unused_shamt;
  assign unused_shamt = ^{up_s, s_q};

  // A stage may load if it or any stage downstream of it is empty, or if the
  // sink takes the final result this cycle. Accumulated from the output end.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      acc    = acc | ~v_q[k];
      rdy[k] = acc;
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_v[k] = in_valid;
      assign up_d[k] = in_data;
      assign up_s[k] = in_shamt;
      assign up_t[k] = in_tag;
    end else begin : g_rest
      assign up_v[k] = v_q[k-1];
      assign up_d[k] = d_q[k-1];
      assign up_s[k] = s_q[k-1];
      assign up_t[k] = t_q[k-1];
    end

    assign d_d[k] = up_s[k][k] ? (up_d[k] >> (1 << k)) : up_d[k];

    // Stage register: load the upstream operation (or a bubble) when ready,
    // otherwise hold everything so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        s_q[k] <= '0;
        t_q[k] <= '0;
      end else if (rdy[k]) begin
        v_q[k] <= up_v[k];
        d_q[k] <= d_d[k];
        s_q[k] <= up_s[k];
        t_q[k] <= up_t[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[SHW-1];
  assign out_data  = d_q[SHW-1];
  assign out_tag   = t_q[SHW-1];

endmodule
